// File: rtl/controlador_sensor_distancia_pkg.sv
// ---------------------------------------------------------------------------
// controlador_sensor_distancia_pkg
// Shared definitions for the ultrasonic distance-sensor controller:
//   - estado_t      : controller FSM states
//   - ROM_IDX_W     : width of the mapping-ROM index (unit count)
//   - MAP_W         : width of the mapped (scaled) ROM value
//   - MAX_UNITS_DEF : default saturation value of the unit count
//   - cnt_w()       : counter width able to hold 0..n-1 (never below 1)
// ---------------------------------------------------------------------------
package controlador_sensor_distancia_pkg;

  localparam int ROM_IDX_W     = 9;
  localparam int MAP_W         = 8;
  localparam int MAX_UNITS_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIGGER,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_LOOKUP
  } estado_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controlador_sensor_distancia_sincronizador_2ff.sv
// ---------------------------------------------------------------------------
// sincronizador_2ff
// Generic two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both stages clear to 0)
//   d     : asynchronous input
//   q     : synchronised output, two clk edges behind d
// ---------------------------------------------------------------------------
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] etapa1;

  // NOTE: both stages are reset so the synchronised value is a known 0 out of
  // reset; sequential state is always updated with non-blocking assignments
  // so the two stages really form a two-deep shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etapa1 <= '0;
      q      <= '0;
    end else begin
      etapa1 <= d;
      q      <= etapa1;
    end
  end

endmodule

// File: rtl/controlador_sensor_distancia.sv
// ---------------------------------------------------------------------------
// controlador_sensor_distancia
// Sequences an ultrasonic range sensor: periodic trigger pulse, echo-width
// timing in quantised distance units with saturation and timeout, lookup in
// an external combinational mapping ROM, and a registered result with a
// one-cycle valid strobe.
// Ports:
//   clk               : system clock
//   rst_n             : asynchronous active-low reset
//   habilitar         : enable periodic measurement
//   echo              : sensor echo pin (asynchronous)
//   trig              : sensor trigger pin
//   rom_distancia     : index to mapping ROM (registered unit count)
//   rom_mapeada       : ROM output, combinational from rom_distancia
//   distancia         : last measured unit count (0..MAX_UNITS)
//   distancia_mapeada : last ROM value
//   valido            : one-cycle pulse, new result available
//   error_timeout     : last result came from a timeout
//   ocupado           : high in every state except IDLE
// ---------------------------------------------------------------------------
module controlador_sensor_distancia
  import controlador_sensor_distancia_pkg::*;
#(
  parameter int TRIG_CYCLES     = 1000,
  parameter int CYCLES_PER_UNIT = 29000,
  parameter int MAX_UNITS       = MAX_UNITS_DEF,
  parameter int TIMEOUT_CYCLES  = 3000000,
  parameter int PERIOD_CYCLES   = 6000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 habilitar,
  input  logic                 echo,
  output logic                 trig,
  output logic [ROM_IDX_W-1:0] rom_distancia,
  input  logic [MAP_W-1:0]     rom_mapeada,
  output logic [ROM_IDX_W-1:0] distancia,
  output logic [MAP_W-1:0]     distancia_mapeada,
  output logic                 valido,
  output logic                 error_timeout,
  output logic                 ocupado
);

  localparam int PER_W = cnt_w(PERIOD_CYCLES);
  localparam int TRG_W = cnt_w(TRIG_CYCLES);
  localparam int TMO_W = cnt_w(TIMEOUT_CYCLES);
  localparam int SUB_W = cnt_w(CYCLES_PER_UNIT);

  localparam logic [PER_W-1:0]     PER_MAX  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TRG_W-1:0]     TRG_MAX  = TRG_W'(TRIG_CYCLES - 1);
  localparam logic [TMO_W-1:0]     TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SUB_W-1:0]     SUB_MAX  = SUB_W'(CYCLES_PER_UNIT - 1);
  localparam logic [ROM_IDX_W-1:0] UNIT_MAX = ROM_IDX_W'(MAX_UNITS);

  estado_t          estado, estado_sig;
  logic             echo_s;
  logic [PER_W-1:0] periodo_cnt;
  logic [TRG_W-1:0] trig_cnt;
  logic [TMO_W-1:0] timeout_cnt;
  logic [SUB_W-1:0] sub_cnt;
  logic             flag_timeout;
  logic             fin_timeout;

  sincronizador_2ff #(.WIDTH(1)) u_sinc_echo (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  // Decoded from the state so that trig drops as soon as reset asserts.
  assign trig    = (estado == ST_TRIGGER);
  assign ocupado = (estado != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= ST_IDLE;
    else        estado <= estado_sig;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    estado_sig  = estado;
    fin_timeout = 1'b0;
    unique case (estado)
      ST_IDLE: begin
        if (periodo_cnt == PER_MAX && habilitar) estado_sig = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        if (trig_cnt == TRG_MAX) estado_sig = ST_WAIT_ECHO;
      end
      ST_WAIT_ECHO: begin
        if (echo_s) begin
          estado_sig = ST_MEASURE;
        end else if (timeout_cnt == TMO_MAX) begin
          estado_sig  = ST_LOOKUP;
          fin_timeout = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_s) begin
          estado_sig = ST_LOOKUP;
        end else if (timeout_cnt == TMO_MAX) begin
          estado_sig  = ST_LOOKUP;
          fin_timeout = 1'b1;
        end
      end
      ST_LOOKUP: estado_sig = ST_IDLE;
      default:   estado_sig = ST_IDLE;
    endcase
  end

  // Counters and the registered ROM index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodo_cnt   <= '0;
      trig_cnt      <= '0;
      timeout_cnt   <= '0;
      sub_cnt       <= '0;
      rom_distancia <= '0;
      flag_timeout  <= 1'b0;
    end else begin
      // Trigger-to-trigger spacing: free-running, saturating, restarted only
      // when a new trigger begins.
      if (estado == ST_IDLE && estado_sig == ST_TRIGGER) periodo_cnt <= '0;
      else if (periodo_cnt != PER_MAX)                   periodo_cnt <= periodo_cnt + PER_W'(1);

      if (estado == ST_TRIGGER && estado_sig == ST_TRIGGER) trig_cnt <= trig_cnt + TRG_W'(1);
      else                                                  trig_cnt <= '0;

      // Restarts on every state change, so WAIT_ECHO and MEASURE each get a
      // full timeout budget.
      if ((estado == ST_WAIT_ECHO || estado == ST_MEASURE) && estado_sig == estado)
        timeout_cnt <= timeout_cnt + TMO_W'(1);
      else
        timeout_cnt <= '0;

      if (estado == ST_WAIT_ECHO && estado_sig == ST_MEASURE) begin
        sub_cnt <= '0;
      end else if (estado == ST_MEASURE && echo_s) begin
        sub_cnt <= (sub_cnt == SUB_MAX) ? '0 : sub_cnt + SUB_W'(1);
      end

      // Unit count only advances on a completed unit, so a partial unit at
      // the end of the echo is discarded (floor).
      if (fin_timeout) begin
        rom_distancia <= UNIT_MAX;
      end else if (estado == ST_WAIT_ECHO && estado_sig == ST_MEASURE) begin
        rom_distancia <= '0;
      end else if (estado == ST_MEASURE && echo_s && sub_cnt == SUB_MAX &&
                   rom_distancia != UNIT_MAX) begin
        rom_distancia <= rom_distancia + ROM_IDX_W'(1);
      end

      if (estado != ST_LOOKUP && estado_sig == ST_LOOKUP) flag_timeout <= fin_timeout;
    end
  end

  // Result registers: loaded on the edge that ends LOOKUP, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      distancia         <= '0;
      distancia_mapeada <= '0;
      error_timeout     <= 1'b0;
      valido            <= 1'b0;
    end else begin
      valido <= (estado == ST_LOOKUP);
      if (estado == ST_LOOKUP) begin
        distancia         <= rom_distancia;
        distancia_mapeada <= rom_mapeada;
        error_timeout     <= flag_timeout;
      end
    end
  end

endmodule
